// File: rtl/sim_run_ctrl.sv
`default_nettype none
// ============================================================================
// sim_run_ctrl : bounded run sequencer with sample strobes, pause and drain.
// Optional watchdog abort enabled by macro RUN_CTRL_WATCHDOG_EN.  Rev 1.0
// ============================================================================
module sim_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int PERIOD_W     = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int WD_CYCLES    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    run_len,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic                pause,
  input  logic                activity,
  output logic                busy,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic                sample_tick,
  output logic                finish_req,
  output logic                done,
  output logic                abort
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_RUN   = 3'd1;
  localparam logic [2:0] c_ST_PAUSE = 3'd2;
  localparam logic [2:0] c_ST_DRAIN = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  localparam int c_DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_len;
  logic [PERIOD_W-1:0]  r_period;
  logic [CNT_W-1:0]     r_cnt;
  logic [PERIOD_W-1:0]  r_phase;
  logic [c_DRAIN_W-1:0] r_drain;
  logic                 r_tick;
  logic                 r_finish;
  logic                 r_done;
  logic                 r_busy;

  logic w_last;
  logic w_tick_hit;
  logic w_cnt_max;
  logic w_wd_hit;

  assign w_last     = (r_cnt == (r_len - CNT_W'(1)));
  assign w_cnt_max  = &r_cnt;
  assign w_tick_hit = (r_period != '0) && (r_phase == (r_period - PERIOD_W'(1)));

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam int c_WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WD_CYCLES - 1);

  logic [c_WD_W-1:0] r_idle;
  logic              r_abort;

  // The watchdog fires on the idle cycle that would bring the count to the limit.
  assign w_wd_hit = !activity && (r_idle == c_WD_LAST);
  assign abort    = r_abort;
`else
  logic w_unused_wd;

  assign w_wd_hit    = 1'b0;
  assign abort       = 1'b0;
  assign w_unused_wd = activity ^ (WD_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_ST_IDLE;
      r_len    <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_drain  <= '0;
      r_tick   <= 1'b0;
      r_finish <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
      r_idle   <= '0;
      r_abort  <= 1'b0;
`endif
    end else begin
      r_tick   <= 1'b0;
      r_finish <= 1'b0;
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (start) begin
            r_len    <= run_len;
            r_period <= sample_period;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_drain  <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= (run_len != '0) ? c_ST_RUN : c_ST_DRAIN;
`ifdef RUN_CTRL_WATCHDOG_EN
            r_idle   <= '0;
            r_abort  <= 1'b0;
`endif
          end
        end
        c_ST_RUN: begin
          // Pause takes precedence over the final-cycle increment.
          if (pause) begin
            r_state <= c_ST_PAUSE;
          end else begin
            if (!w_cnt_max) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_tick_hit) begin
              r_phase <= '0;
              r_tick  <= 1'b1;
            end else begin
              r_phase <= r_phase + PERIOD_W'(1);
            end
`ifdef RUN_CTRL_WATCHDOG_EN
            r_idle <= activity ? '0 : (r_idle + c_WD_W'(1));
            if (w_wd_hit) begin
              r_abort <= 1'b1;
            end
`endif
            if (w_last || w_wd_hit) begin
              r_state <= c_ST_DRAIN;
              r_drain <= '0;
            end
          end
        end
        c_ST_PAUSE: begin
          if (!pause) begin
            r_state <= c_ST_RUN;
          end
        end
        c_ST_DRAIN: begin
          if (r_drain == c_DRAIN_LAST) begin
            r_state  <= c_ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_finish <= 1'b1;
          end else begin
            r_drain <= r_drain + c_DRAIN_W'(1);
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign cycle_cnt   = r_cnt;
  assign sample_tick = r_tick;
  assign finish_req  = r_finish;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
// Bench for sim_run_ctrl: directed and randomized runs against a timeline model.
module tb_sim_run_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] run_len;
  logic [15:0] sample_period;
  logic        pause;
  logic        activity;
  logic        busy;
  logic [31:0] cycle_cnt;
  logic        sample_tick;
  logic        finish_req;
  logic        done;
  logic        abort;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sim_run_ctrl #(
    .CNT_W(32), .PERIOD_W(16), .DRAIN_CYCLES(D), .WD_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len),
    .sample_period(sample_period), .pause(pause), .activity(activity),
    .busy(busy), .cycle_cnt(cycle_cnt), .sample_tick(sample_tick),
    .finish_req(finish_req), .done(done), .abort(abort)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count value t edges after the start edge: pause of K samples at count A
  // inserts K+1 non-counting edges; the count never exceeds L.
  function automatic int exp_cnt(input int t, input int L, input int A, input int K);
    int c;
    if (t <= 0) c = 0;
    else if (K == 0 || t <= A) c = t;
    else if (t <= A + K + 1) c = A;
    else c = t - K - 1;
    if (c > L) c = L;
    return c;
  endfunction

  // One complete run from the start edge through one cycle past DONE entry.
  task automatic run(input int L, input int P, input int A, input int K, input int gt);
    int T, ticks, c, cp;
    bit et;
    T = L + D + ((K > 0) ? K + 1 : 0);
    ticks = 0;
    start = 1'b1; run_len = L; sample_period = 16'(P); pause = 1'b0;
    step();
    start = 1'b0; run_len = $urandom; sample_period = 16'($urandom);
    for (int t = 0; t <= T + 1; t++) begin
      c  = exp_cnt(t, L, A, K);
      cp = exp_cnt(t - 1, L, A, K);
      et = (t >= 1) && (P != 0) && (c > cp) && (c % P == 0);
      chk("cycle_cnt", cycle_cnt, c);
      chk("sample_tick", sample_tick, et);
      chk("finish_req", finish_req, t == T);
      chk("done", done, t >= T);
      chk("busy", busy, t < T);
      chk("abort", abort, 1'b0);
      if (sample_tick === 1'b1) ticks++;
      // inputs for the next edge
      start = 1'b0;
      pause = (K > 0) && (t + 1 >= A + 1) && (t + 1 <= A + K);
      if (t >= T - D && t < T) pause = 1'($urandom);
      if (t + 1 == gt) begin
        start = 1'b1; run_len = $urandom_range(1, 50);
      end
      if (t <= T) step();
    end
    chk("tick_total", ticks, (P == 0) ? 0 : L / P);
    start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    int L, P, A, K, gt;
    rst = 1'b1; start = 1'b0; run_len = '0; sample_period = '0;
    pause = 1'b0; activity = 1'b0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_tick", sample_tick, 1'b0);
    chk("rst_finish", finish_req, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_abort", abort, 1'b0);
    rst = 1'b0;
    step();

    run(10, 3, 0, 0, -1);
    run(10, 3, 4, 5, -1);
    run(0, 3, 0, 0, -1);
    run(10, 0, 0, 0, -1);
    run(10, 1, 0, 0, -1);
    run(10, 3, 0, 0, 5);

    // reset in the middle of a run
    start = 1'b1; run_len = 10; sample_period = 3;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("mid_cnt", cycle_cnt, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_cnt", cycle_cnt, 0);
      chk("mrst_tick", sample_tick, 1'b0);
      chk("mrst_finish", finish_req, 1'b0);
      chk("mrst_done", done, 1'b0);
      step();
    end
    run(2, 1, 0, 0, -1);

    // start coincident with reset
    rst = 1'b1; start = 1'b1; run_len = 7;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 1'b0);
    chk("rst_start_done", done, 1'b0);
    step();
    chk("idle_hold_busy", busy, 1'b0);

    for (int r = 0; r < 25; r++) begin
      L  = $urandom_range(0, 30);
      P  = $urandom_range(0, 6);
      K  = (L > 0) ? $urandom_range(0, 6) : 0;
      A  = (L > 0) ? $urandom_range(0, L - 1) : 0;
      gt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, L + D - 1) : -1;
      run(L, P, A, K, gt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
